// File: rtl/onehot_scan_decoder_if.sv
// Bus bundle for onehot_scan_decoder: control/index inputs and the registered
// one-hot, index and wrap outputs. The controller side uses the master modport,
// the decoder uses the slave modport.
interface onehot_scan_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] a;
  logic [N-1:0]     y;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, load, a,
    input  y, idx, wrap
  );

  modport slave (
    input  en, mode, load, a,
    output y, idx, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W -> 2^SEL_W one-hot decoder with a built-in scan sequencer.
// mode=0 decodes the loaded index; mode=1 steps the active output through all
// positions, holding each for DWELL enabled cycles, and pulses wrap on N-1 -> 0.
// Build option: define DEC_ACTIVE_LOW_OUT_EN for an active-low y (selected bit 0,
// blanked/reset value all ones). Default build is active-high.
//
// No FSM states: the sequencer is just the index register plus a dwell counter.
//   register | meaning
//   idx_q    | current index, always mirrored by y_q in the same cycle
//   cnt_q    | enabled cycles spent at idx_q in scan mode (0..DWELL-1)
//   y_q      | one-hot (or blanked) image of idx_q
//   wrap_q   | scan stepped from N-1 to 0 on the last edge
module onehot_scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  onehot_scan_decoder_if.slave  bus
);
  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

`ifdef DEC_ACTIVE_LOW_OUT_EN
  localparam logic [N-1:0] Y_OFF = '1;
`else
  localparam logic [N-1:0] Y_OFF = '0;
`endif

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     y_q, y_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     onehot;

  // State registers; reset forces the blanked output immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      y_q    <= Y_OFF;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  // Next index/counter with load > direct > scan-step > scan-count > freeze,
  // then decode the *next* index so y and idx always agree.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    onehot = '0;

    if (bus.load) begin
      idx_d = bus.a;
      cnt_d = '0;
    end else if (!bus.mode) begin
      cnt_d = '0;
    end else if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = &idx_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    onehot[idx_d] = 1'b1;
`ifdef DEC_ACTIVE_LOW_OUT_EN
    y_d = bus.en ? ~onehot : Y_OFF;
`else
    y_d = bus.en ? onehot : Y_OFF;
`endif
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Bench for onehot_scan_decoder: a SEL_W=3/DWELL=4 instance driven from a vector
// table, and a SEL_W=2/DWELL=3 instance exercised with hand-written scan,
// freeze, load-priority and asynchronous-reset sequences.
module tb_onehot_scan_decoder;
  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 if (clk_run) clk = ~clk;

  onehot_scan_decoder_if #(.SEL_W(3)) b8 ();
  onehot_scan_decoder_if #(.SEL_W(2)) b4 ();

  onehot_scan_decoder #(.SEL_W(3), .DWELL(4)) dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(b8.slave));
  onehot_scan_decoder #(.SEL_W(2), .DWELL(3)) dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(b4.slave));

  typedef struct {
    logic       en;
    logic       mode;
    logic       load;
    logic [2:0] a;
    logic [7:0] y;      // active-high expectation
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [7:0] pol8(input logic [7:0] v);
`ifdef DEC_ACTIVE_LOW_OUT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] pol4(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_OUT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk4(input string name, input logic [3:0] y_hi, input logic [1:0] idx, input logic wrap);
    check({name, ".y"}, 32'(b4.y), 32'(pol4(y_hi)));
    check({name, ".idx"}, 32'(b4.idx), 32'(idx));
    check({name, ".wrap"}, 32'(b4.wrap), 32'(wrap));
  endtask

  initial begin
    // en mode load a | y idx wrap
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 3'd5, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 3'd7, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 3'd3, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h10, 3'd4, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd4, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 3'd4, 1'b0};

    rst_n = 1'b0;
    b8.en = 1'b0; b8.mode = 1'b0; b8.load = 1'b0; b8.a = '0;
    b4.en = 1'b0; b4.mode = 1'b0; b4.load = 1'b0; b4.a = '0;

    // Reset with the clock stopped.
    #3;
    check("rst8.y", 32'(b8.y), 32'(pol8(8'h00)));
    check("rst8.idx", 32'(b8.idx), 32'd0);
    check("rst8.wrap", 32'(b8.wrap), 32'd0);
    chk4("rst4", 4'b0000, 2'd0, 1'b0);

    clk_run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b4.en = 1'b1; b4.mode = 1'b1;
    rst_n = 1'b1;

    // Scan from reset: first step on the 3rd edge, wrap on the 12th.
    for (int e = 1; e <= 13; e++) begin
      tick();
      chk4($sformatf("scan_e%0d", e), 4'(1 << ((e / 3) % 4)), 2'((e / 3) % 4), (e % 12) == 0);
    end

    // Freeze mid-dwell (idx0, cnt1) for 5 edges.
    b4.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk4($sformatf("frz%0d", i), 4'b0000, 2'd0, 1'b0);
    end
    b4.en = 1'b1;
    tick();
    chk4("resume0", 4'b0001, 2'd0, 1'b0);
    tick();
    chk4("resume_step", 4'b0010, 2'd1, 1'b0);

    // Load on the step edge wins; counter restarts.
    tick();
    chk4("pre_ld1", 4'b0010, 2'd1, 1'b0);
    tick();
    chk4("pre_ld2", 4'b0010, 2'd1, 1'b0);
    b4.load = 1'b1; b4.a = 2'd2;
    tick();
    b4.load = 1'b0; b4.a = 2'd0;
    chk4("ld_step", 4'b0100, 2'd2, 1'b0);
    tick();
    chk4("ld_c1", 4'b0100, 2'd2, 1'b0);
    tick();
    chk4("ld_c2", 4'b0100, 2'd2, 1'b0);
    tick();
    chk4("ld_next", 4'b1000, 2'd3, 1'b0);
    tick();
    chk4("at3", 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset between edges at idx3.
    #2 rst_n = 1'b0;
    #1;
    chk4("arst", 4'b0000, 2'd0, 1'b0);
    check("arst8.y", 32'(b8.y), 32'(pol8(8'h00)));
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk4($sformatf("restart_e%0d", e), 4'(1 << (e / 3)), 2'(e / 3), 1'b0);
    end

    // Table-driven vectors on the 8-output instance.
    for (int i = 0; i < 20; i++) begin
      b8.en = vecs[i].en; b8.mode = vecs[i].mode;
      b8.load = vecs[i].load; b8.a = vecs[i].a;
      tick();
      check($sformatf("v%0d.y", i), 32'(b8.y), 32'(pol8(vecs[i].y)));
      check($sformatf("v%0d.idx", i), 32'(b8.idx), 32'(vecs[i].idx));
      check($sformatf("v%0d.wrap", i), 32'(b8.wrap), 32'(vecs[i].wrap));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised registered one-hot decoder: SEL_W-bit index to 2^SEL_W one-hot output, with an optional built-in scan sequencer. In direct mode it decodes a loaded index. In scan mode it steps the active output through all positions at a fixed dwell rate, for example for digit multiplexing of seven-segment displays. It sits between control logic and multiplexed board I/O, replacing the combinational 2-to-4 and 3-to-8 one-hot decoders wherever a registered or scanned select is needed.

## Interface
- SEL_W, 3, index width; output width N = 2^SEL_W; legal range 1..6
- DWELL, 4, cycles each position is held in scan mode; legal range 1..65535
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  output enable; when 0, the output is blanked and the scan is frozen
- mode  in  1  0 = direct decode, 1 = scan
- load  in  1  one-cycle strobe; captures a into the index register
- a  in  SEL_W  index to load
- y  out  N  registered one-hot output
- idx  out  SEL_W  current index register
- wrap  out  1  one-cycle pulse when scan advances from N-1 to 0

## Operation
- State: idx register (SEL_W bits), dwell counter cnt (clog2(DWELL) bits, minimum 1), y register, wrap register.
- Reset (rst_n=0, asynchronous): idx=0, cnt=0, y=all-inactive, wrap=0. Release is taken synchronously at the next edge.
- Index update priority at each edge, highest first:
  - load=1: idx<=a, cnt<=0. load acts regardless of en and mode.
  - mode=0: idx holds, cnt<=0.
  - mode=1, en=1, cnt==DWELL-1: cnt<=0, idx<=idx+1 modulo N.
  - mode=1, en=1, otherwise: cnt<=cnt+1.
  - mode=1, en=0: cnt and idx hold (frozen).
- wrap<=1 only on an edge where the scan step takes idx from N-1 to 0. A load never asserts wrap, even if a==0. Otherwise wrap<=0.
- Output: y<=en ? onehot(next idx) : inactive. Bit k of y is active iff k == next idx.
- Exactly one y bit is active whenever en was 1 at the previous edge. No bits are active otherwise.
- A mode change from 1 to 0 clears cnt. A mode change from 0 to 1 starts counting from cnt=0.
- DWELL=1: idx advances every enabled cycle.
- SEL_W=1: N=2 and the scan toggles between bits 0 and 1.

## Timing
- Latency: a change of load, a, or en is visible on y and idx one edge later. y and idx always agree in the same cycle.
- Scan period: N*DWELL enabled cycles per full rotation. wrap fires once per rotation.
- After reset release with en=1 and mode=1:
  - y=onehot(0) from the first edge.
  - The first step to idx=1 occurs on the DWELL-th edge.
- Reset asserted mid-scan forces the reset values immediately, without waiting for a clock edge.
- The block has no combinational path from inputs to outputs.

## Configuration
- DEC_ACTIVE_LOW_OUT_EN defined: y is active-low. The selected bit is 0 and the others are 1. Blanked and reset value is all ones. idx and wrap are unaffected.
- DEC_ACTIVE_LOW_OUT_EN undefined: y is active-high. The selected bit is 1. Blanked and reset value is all zeros.

## Test plan
- Reset: hold rst_n=0 with the clock stopped -> y=8'h00, idx=0, wrap=0 immediately (SEL_W=3, macro off).
- Direct decode: mode=0, en=1, load pulse with a=5 -> next cycle y=8'h20, idx=5. Then en=0 -> next cycle y=8'h00 and idx stays 5.
- Scan timing: SEL_W=2, DWELL=3, mode=1, en=1 from reset.
  - y sequence is 0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001.
  - wrap is high for exactly one cycle, coincident with the return to 0001.
- Freeze and priority:
  - Scan with en dropped for 5 cycles mid-dwell -> y=0 for those cycles, then resumes at the same idx with the remaining dwell count.
  - load a=2 on the step cycle -> idx=2 and cnt restarts; no wrap.
- Mid-operation reset: assert rst_n asynchronously during a scan at idx=3 -> y, idx, cnt and wrap are cleared before the next edge. Scanning restarts from 0 after release.
- Macro on: SEL_W=3, direct load a=0 -> y=8'hFE. en=0 -> y=8'hFF. Reset value -> 8'hFF.
